seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
// Time-multiplexing scheduler for the shared 7-segment cathode bus of the 8-digit display.
// Grants the bus to one anode at a time, with a blanking guard between digits to prevent ghosting.
// Captures a coherent snapshot of the 8 hex nibbles at each frame start.
// Sits between the counter/datapath in top and the top_cc/top_an board pins.
// PARAMETERS
// DIGITS      8       number of digits scanned (index width 3)
// REFRESH_DIV 100000  sys_clk cycles each digit is lit (>=1)
// GUARD_CYC   2       sys_clk cycles all anodes off between digits (0 = no guard)
// PORTS
// sys_clk     in   1         system clock, rising edge
// rst         in   1         asynchronous, active-high reset
// en          in   1         1 = scan, 0 = display dark
// digit_data  in   4*DIGITS  hex nibbles; [3:0] = digit 0 (least significant)
// digit_mask  in   DIGITS    1 = digit allowed to light
// blank_lz    in   1         1 = suppress leading zeros (digit 0 never suppressed)
// cc          out  7         cathodes {g,f,e,d,c,b,a}, active-low
// an          out  DIGITS    anodes, active-low, at most one low
// digit_idx   out  3         digit currently owning the bus
// frame_done  out  1         1-cycle pulse when the last digit's slot ends
// BEHAVIOUR
// - Reset (async, immediate): an=all 1, cc=7'h7F, digit_idx=0, frame_done=0, state IDLE, prescaler=0.
// - All outputs are registered. an/cc change on the same edge the state register changes.
// - States: IDLE, SHOW, GUARD.
//   IDLE : an=all 1, cc=7F. On an edge with en=1: snapshot<=digit_data, idx<=0, go SHOW.
//   SHOW : lasts exactly REFRESH_DIV cycles.
//     an[idx]=0 only if digit_mask[idx]=1 and idx is not blanked.
//     cc=decode(snapshot nibble idx), or 7F when the anode is off.
//     Then go GUARD (or straight to next digit if GUARD_CYC=0).
//   GUARD: lasts exactly GUARD_CYC cycles, with an=all 1, cc=7F. Then advance the index:
//     idx<DIGITS-1 : idx+1, go SHOW.
//     idx=DIGITS-1 : idx wraps to 0, frame_done=1 for 1 cycle, snapshot re-latched, go SHOW.
// - Frame length = DIGITS*(REFRESH_DIV+GUARD_CYC) cycles.
// - en=0 in any state: next edge -> IDLE, an all 1, prescaler cleared, no frame_done pulse.
//   A later en=1 restarts at digit 0 with a fresh snapshot.
// - Changes to digit_data mid-frame have no visible effect until the next frame boundary.
//   digit_mask and blank_lz are sampled live.
// - Leading-zero blanking: digit i>0 is blanked when blank_lz=1 and snapshot nibbles i..DIGITS-1 are all 0.
// - Decode 0-F -> 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex).
// - Prescaler counts 0..REFRESH_DIV-1 (resp. GUARD_CYC-1), reloads to 0 on each state change. No overflow possible.
// TESTING (REFRESH_DIV=4, GUARD_CYC=1, DIGITS=8)
// 1. Hold rst=1 for several clocks
//    -> an=FF, cc=7F, frame_done=0; asserting rst mid-frame forces an=FF with no clock edge.
// 2. digit_data=32'h76543210, mask=FF, en=1
//    -> an FE(4 cycles, cc=40), FF(1), FD(4, cc=79), FF(1), ... 7F(4, cc=78);
//    frame_done pulses once every 40 cycles.
// 3. blank_lz=1, data=32'h00000305
//    -> digits 0,1,2 show 12,40,30; slots 3-7 keep an=FF.
//    data=0 -> digit 0 shows 40, others dark.
// 4. digit_mask=8'hFD -> digit 1 slot has an=FF, cc=7F; timing unchanged (still 40-cycle frame).
// 5. Write data=32'h89ABCDEF during digit 3
//    -> digits 4-7 still show the old nibbles; new values appear after frame_done.
// 6. Drop en during SHOW of digit 5 -> next edge an=FF, no frame_done;
//    re-raise en -> scan restarts at digit 0 (an=FE).

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a shared 7-segment cathode bus.
// One anode lit at a time with an all-dark guard gap between digits.
// The nibble snapshot refreshes only at frame boundaries.
module seg_scan_ctrl #(
   parameter int DIGITS      = 8,
   parameter int REFRESH_DIV = 100000,
   parameter int GUARD_CYC   = 2
) (
   input  logic                        sys_clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic [4*DIGITS-1:0]         digit_data,
   input  logic [DIGITS-1:0]           digit_mask,
   input  logic                        blank_lz,
   output logic [6:0]                  cc,
   output logic [DIGITS-1:0]           an,
   output logic [$clog2(DIGITS)-1:0]   digit_idx,
   output logic                        frame_done
);

   localparam int IW   = $clog2(DIGITS);
   localparam int CMAX = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
   localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
   localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

   typedef enum logic [1:0] {IDLE, SHOW, GUARD} state_t;

   state_t              state, state_n;
   logic [CW-1:0]       cnt, cnt_n;
   logic [IW-1:0]       idx_n;
   logic [4*DIGITS-1:0] snap, snap_n;
   logic                fd_n;
   logic                adv;
   logic                lit;
   logic [3:0]          nib;
   logic [DIGITS-1:0]   an_n;
   logic [6:0]          cc_n;

   // Hex nibble to active-low {g,f,e,d,c,b,a}.
   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   // True when nibbles i..DIGITS-1 of the snapshot are all zero.
   function automatic logic upper_zero(input logic [4*DIGITS-1:0] s, input logic [IW-1:0] i);
      logic z;
      z = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (k >= int'(i) && s[4*k +: 4] != 4'h0) z = 1'b0;
      end
      return z;
   endfunction

   // Next-state: slot timing, digit advance, frame wrap and snapshot reload.
   always_comb begin
      state_n = state;
      cnt_n   = cnt + CW'(1);
      idx_n   = digit_idx;
      snap_n  = snap;
      fd_n    = 1'b0;
      adv     = 1'b0;
      if (!en) begin
         state_n = IDLE;
         cnt_n   = '0;
         idx_n   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_n = SHOW;
               cnt_n   = '0;
               idx_n   = '0;
               snap_n  = digit_data;
            end
            SHOW: begin
               if (cnt == SHOW_LAST) begin
                  cnt_n = '0;
                  if (GUARD_CYC > 0) state_n = GUARD;
                  else               adv     = 1'b1;
               end
            end
            GUARD: begin
               if (cnt == GUARD_LAST) begin
                  cnt_n = '0;
                  adv   = 1'b1;
               end
            end
            default: begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         endcase
         if (adv) begin
            state_n = SHOW;
            if (digit_idx == LAST_IDX) begin
               idx_n  = '0;
               fd_n   = 1'b1;
               snap_n = digit_data;
            end else begin
               idx_n = digit_idx + IW'(1);
            end
         end
      end
   end

   // Output drive for the upcoming cycle; mask and blanking act live.
   always_comb begin
      nib  = snap_n[4*idx_n +: 4];
      lit  = (state_n == SHOW) && digit_mask[idx_n] &&
             !(blank_lz && (idx_n != '0) && upper_zero(snap_n, idx_n));
      an_n = lit ? ~(DIGITS'(1) << idx_n) : '1;
      cc_n = lit ? decode(nib) : 7'h7F;
   end

   // State and all outputs register together so an/cc move with the state.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         snap       <= '0;
         digit_idx  <= '0;
         frame_done <= 1'b0;
         an         <= '1;
         cc         <= 7'h7F;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         snap       <= snap_n;
         digit_idx  <= idx_n;
         frame_done <= fd_n;
         an         <= an_n;
         cc         <= cc_n;
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-based scan model plus literal spot checks.
// Model tracks cycles since scan start; outputs derive from frame position.
// Inputs change on falling edges; outputs are compared on falling edges.
module tb_seg_scan_ctrl;

   localparam int RD    = 4;
   localparam int GC    = 1;
   localparam int ND    = 8;
   localparam int SLOT  = RD + GC;
   localparam int FRAME = ND * SLOT;

   logic        sys_clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [31:0] digit_data = '0;
   logic [7:0]  digit_mask = 8'hFF;
   logic        blank_lz = 1'b0;
   logic [6:0]  cc;
   logic [7:0]  an;
   logic [2:0]  digit_idx;
   logic        frame_done;

   int errors = 0;
   int checks = 0;

   seg_scan_ctrl #(.DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYC(GC)) dut (
      .sys_clk(sys_clk), .rst(rst), .en(en), .digit_data(digit_data),
      .digit_mask(digit_mask), .blank_lz(blank_lz), .cc(cc), .an(an),
      .digit_idx(digit_idx), .frame_done(frame_done)
   );

   always #5 sys_clk = ~sys_clk;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position inside the frame decides every output.
   bit          running = 0;
   int unsigned t = 0;
   logic [31:0] snap = '0;
   logic [7:0]  e_an = 8'hFF;
   logic [6:0]  e_cc = 7'h7F;
   logic [2:0]  e_idx = '0;
   logic        e_fd = 1'b0;

   always @(posedge sys_clk or posedge rst) begin
      int unsigned p, slot;
      bit show, lit;
      if (rst || !en) begin
         running = 0;
         e_an = 8'hFF; e_cc = 7'h7F; e_idx = 0; e_fd = 0;
      end else begin
         if (!running) begin
            running = 1; t = 0; snap = digit_data; e_fd = 0;
         end else begin
            t++;
            e_fd = (t % FRAME == 0);
            if (e_fd) snap = digit_data;
         end
         p    = t % FRAME;
         slot = p / SLOT;
         show = (p % SLOT) < RD;
         lit  = show && digit_mask[slot] &&
                !(blank_lz && slot > 0 && (snap >> (4 * slot)) == 0);
         e_idx = slot[2:0];
         e_an  = lit ? ~(8'd1 << slot) : 8'hFF;
         e_cc  = lit ? dec[(snap >> (4 * slot)) & 32'hF] : 7'h7F;
      end
   end

   // Per-cycle comparison against the model (or reset literals).
   always @(negedge sys_clk) begin
      if (rst) begin
         check("rst_an", an, 8'hFF);
         check("rst_cc", cc, 7'h7F);
         check("rst_fd", frame_done, 0);
         check("rst_idx", digit_idx, 0);
      end else begin
         check("an", an, e_an);
         check("cc", cc, e_cc);
         check("digit_idx", digit_idx, e_idx);
         check("frame_done", frame_done, e_fd);
      end
   end

   // Stop, restart; on return the next negedge observes t=0.
   task automatic restart();
      en = 1'b0;
      @(negedge sys_clk);
      en = 1'b1;
      @(negedge sys_clk);
   endtask

   task automatic skip(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   initial begin
      int fd_cnt;
      // Reset held for several clocks.
      repeat (4) @(negedge sys_clk);
      rst = 1'b0;

      // Basic scan and frame_done cadence.
      digit_data = 32'h76543210; digit_mask = 8'hFF; blank_lz = 0;
      en = 1'b1;
      @(negedge sys_clk);
      check("t2_first_an", an, 8'hFE);
      check("t2_first_cc", cc, 7'h40);
      skip(4);
      check("t2_guard_an", an, 8'hFF);
      skip(1);
      check("t2_d1_an", an, 8'hFD);
      check("t2_d1_cc", cc, 7'h79);
      skip(30);
      check("t2_d7_an", an, 8'h7F);
      check("t2_d7_cc", cc, 7'h78);
      fd_cnt = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge sys_clk);
         if (frame_done) fd_cnt++;
      end
      check("t2_fd_count", fd_cnt, 2);

      // Leading-zero blanking.
      blank_lz = 1; digit_data = 32'h00000305;
      restart();
      check("t3_d0_cc", cc, 7'h12);
      skip(5);
      check("t3_d1_an", an, 8'hFD);
      check("t3_d1_cc", cc, 7'h40);
      skip(5);
      check("t3_d2_cc", cc, 7'h30);
      skip(5);
      check("t3_d3_an", an, 8'hFF);
      digit_data = 32'h0;
      restart();
      check("t3_zero_d0", cc, 7'h40);
      skip(5);
      check("t3_zero_d1", an, 8'hFF);

      // Masked digit keeps timing.
      blank_lz = 0; digit_data = 32'h76543210; digit_mask = 8'hFD;
      restart();
      skip(5);
      check("t4_d1_an", an, 8'hFF);
      check("t4_d1_cc", cc, 7'h7F);
      skip(5);
      check("t4_d2_cc", cc, 7'h24);
      skip(30);
      check("t4_fd", frame_done, 1);

      // Mid-frame data write waits for the frame boundary.
      digit_mask = 8'hFF;
      restart();
      skip(15);
      digit_data = 32'h89ABCDEF;
      skip(5);
      check("t5_d4_old", cc, 7'h19);
      skip(20);
      check("t5_new_fd", frame_done, 1);
      check("t5_new_d0", cc, 7'h0E);

      // Drop enable mid-show, then restart.
      skip(25);
      en = 1'b0;
      @(negedge sys_clk);
      check("t6_off_an", an, 8'hFF);
      check("t6_off_fd", frame_done, 0);
      en = 1'b1;
      @(negedge sys_clk);
      check("t6_restart_an", an, 8'hFE);

      // Asynchronous reset between clock edges.
      skip(7);
      #2 rst = 1'b1;
      #1;
      check("t1_async_an", an, 8'hFF);
      check("t1_async_cc", cc, 7'h7F);
      skip(3);
      rst = 1'b0;

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         @(negedge sys_clk);
         if ($urandom_range(0, 29) == 0) digit_data = $urandom >> $urandom_range(0, 31);
         if ($urandom_range(0, 49) == 0) digit_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
         if ($urandom_range(0, 59) == 0) blank_lz = ~blank_lz;
         if (en && $urandom_range(0, 199) == 0) en = 1'b0;
         else if (!en && $urandom_range(0, 4) == 0) en = 1'b1;
         if (i == 1500) begin
            #2 rst = 1'b1;
            @(negedge sys_clk);
            @(negedge sys_clk);
            rst = 1'b0;
         end
      end

      @(negedge sys_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
